// File: rtl/imem_responder_pkg.sv
// Shared types and defaults for the instruction-memory responder slice.
package imem_responder_pkg;

  localparam int ADDR_W_DEF     = 16;
  localparam int INST_W_DEF     = 16;
  localparam int DEPTH_LOG2_DEF = 8;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_e;

  // Even parity: the stored bit makes the total number of ones in the word even.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch (IF-->IM-->ID) and program-load signals between the core and imem_responder.
interface imem_responder_if
  import imem_responder_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int INST_W     = INST_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
);
  logic                  req_v_i;
  logic [ADDR_W-1:0]     req_addr_i;
  logic                  stall_i;
  logic                  flush_i;
  logic                  v_o;
  logic [INST_W-1:0]     inst_o;
  logic [ADDR_W-1:0]     origaddr_o;
  logic                  ld_v_i;
  logic [INST_W-1:0]     ld_data_i;
  logic                  ld_done_i;
  logic                  ld_ready_o;
  logic [DEPTH_LOG2:0]   ld_cnt_o;
  logic                  run_o;
`ifdef IMEM_PARITY_EN
  logic                  perr_o;
`endif

  modport master (
    output req_v_i, req_addr_i, stall_i, flush_i, ld_v_i, ld_data_i, ld_done_i,
`ifdef IMEM_PARITY_EN
    input  perr_o,
`endif
    input  v_o, inst_o, origaddr_o, ld_ready_o, ld_cnt_o, run_o
  );

  modport slave (
    input  req_v_i, req_addr_i, stall_i, flush_i, ld_v_i, ld_data_i, ld_done_i,
`ifdef IMEM_PARITY_EN
    output perr_o,
`endif
    output v_o, inst_o, origaddr_o, ld_ready_o, ld_cnt_o, run_o
  );

endinterface

// File: rtl/imem_responder_ram.sv
// DEPTH x WIDTH instruction array: one synchronous write port, one registered read port.
// Dropping i_re keeps the read register unchanged, which is how stall holds inst_o.
module imem_responder_ram #(
  parameter int DEPTH_LOG2 = 8,
  parameter int WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WIDTH-1:0]      i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WIDTH-1:0]      o_rdata
);
  logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The array itself is never reset so a loaded program survives rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: program-load FSM plus 1-cycle fetch with stall/flush.
// Optional IMEM_PARITY_EN stores an even-parity bit per word and suppresses bad responses.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int INST_W     = INST_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input logic              clk,
  input logic              rst,
  imem_responder_if.slave  bus
);
`ifdef IMEM_PARITY_EN
  localparam int RAM_W = INST_W + 1;
`else
  localparam int RAM_W = INST_W;
`endif
  localparam logic [DEPTH_LOG2:0] LP_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LP_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

  imem_state_e          r_state;
  imem_state_e          w_state_nx;
  logic [DEPTH_LOG2:0]  r_cnt;
  logic [DEPTH_LOG2:0]  w_cnt_nx;
  logic                 w_ld_ready;
  logic                 w_we;
  logic                 w_run;
  logic                 w_re;
  logic                 r_v;
  logic                 w_v_nx;
  logic [ADDR_W-1:0]    r_origaddr;
  logic [RAM_W-1:0]     w_wdata;
  logic [RAM_W-1:0]     w_rdata;

  assign w_run      = (r_state == ST_RUN);
  assign w_ld_ready = (r_state == ST_LOAD) && (r_cnt != LP_DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // A word accepted in the same cycle as ld_done_i is still written and counted.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_we       = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_we = bus.ld_v_i && w_ld_ready;
        if (w_we) begin
          w_cnt_nx = r_cnt + LP_ONE;
        end else begin
          w_cnt_nx = r_cnt;
        end
        if (bus.ld_done_i) begin
          w_state_nx = ST_RUN;
        end else begin
          w_state_nx = ST_LOAD;
        end
      end
      ST_RUN: begin
        w_state_nx = ST_RUN;
      end
      default: begin
        w_state_nx = ST_LOAD;
      end
    endcase
  end

  // Flush kills the in-flight response; a request alongside it (not stalled) is the branch target.
  always_comb begin
    w_re   = w_run && bus.req_v_i && !bus.stall_i;
    w_v_nx = r_v;
    if (!w_run) begin
      w_v_nx = 1'b0;
    end else if (bus.flush_i) begin
      w_v_nx = bus.req_v_i && !bus.stall_i;
    end else if (bus.stall_i) begin
      w_v_nx = r_v;
    end else begin
      w_v_nx = bus.req_v_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v        <= 1'b0;
      r_origaddr <= '0;
    end else begin
      r_v <= w_v_nx;
      if (w_re) begin
        r_origaddr <= bus.req_addr_i;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic r_fresh;
  logic w_bad;

  assign w_wdata = {even_parity(64'(bus.ld_data_i)), bus.ld_data_i};
  assign w_bad   = ^w_rdata;

  // perr_o fires only on the cycle a word is first presented, not while stall holds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fresh <= 1'b0;
    end else begin
      r_fresh <= w_re;
    end
  end

  assign bus.v_o    = r_v && !w_bad;
  assign bus.perr_o = r_fresh && r_v && w_bad;
`else
  assign w_wdata = bus.ld_data_i;
  assign bus.v_o = r_v;
`endif

  imem_responder_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (RAM_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_cnt[DEPTH_LOG2-1:0]),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (bus.req_addr_i[DEPTH_LOG2-1:0]),
    .o_rdata (w_rdata)
  );

  assign bus.inst_o     = w_rdata[INST_W-1:0];
  assign bus.origaddr_o = r_origaddr;
  assign bus.ld_ready_o = w_ld_ready;
  assign bus.ld_cnt_o   = r_cnt;
  assign bus.run_o      = w_run;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized bench for imem_responder against a behavioural model (DEPTH_LOG2=2 to exercise wrap/full).
module tb_imem_responder;
  localparam int ADDR_W     = 16;
  localparam int INST_W     = 16;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  imem_responder_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  imem_responder #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: program image, load count, run flag and the expected response.
  logic [INST_W-1:0] m_mem [DEPTH];
  int                m_cnt;
  bit                m_run;
  bit                m_v;
  logic [INST_W-1:0] m_inst;
  logic [ADDR_W-1:0] m_org;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input bit req_v, input logic [ADDR_W-1:0] addr, input bit stall,
                        input bit flush, input bit ld_v, input logic [INST_W-1:0] data,
                        input bit done);
    bus.req_v_i    = req_v;
    bus.req_addr_i = addr;
    bus.stall_i    = stall;
    bus.flush_i    = flush;
    bus.ld_v_i     = ld_v;
    bus.ld_data_i  = data;
    bus.ld_done_i  = done;
  endtask

  task automatic model_edge();
    if (!m_run) begin
      if (bus.ld_v_i && m_cnt < DEPTH) begin
        m_mem[m_cnt % DEPTH] = bus.ld_data_i;
        m_cnt++;
      end
      if (bus.ld_done_i) m_run = 1'b1;
      m_v = 1'b0;
    end else if (bus.flush_i && (bus.stall_i || !bus.req_v_i)) begin
      m_v = 1'b0;
    end else if (bus.stall_i) begin
      m_v = m_v;
    end else if (bus.req_v_i) begin
      m_v    = 1'b1;
      m_inst = m_mem[int'(bus.req_addr_i) % DEPTH];
      m_org  = bus.req_addr_i;
    end else begin
      m_v = 1'b0;
    end
  endtask

  task automatic check_outputs();
    chk("v_o", 32'(bus.v_o), 32'(m_v));
    chk("run_o", 32'(bus.run_o), 32'(m_run));
    chk("ld_cnt_o", 32'(bus.ld_cnt_o), 32'(m_cnt));
    chk("ld_ready_o", 32'(bus.ld_ready_o), 32'(!m_run && m_cnt != DEPTH));
    if (m_v) begin
      chk("inst_o", 32'(bus.inst_o), 32'(m_inst));
      chk("origaddr_o", 32'(bus.origaddr_o), 32'(m_org));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    #1;
    m_run  = 1'b0;
    m_cnt  = 0;
    m_v    = 1'b0;
    m_inst = '0;
    m_org  = '0;
    check_outputs();
    chk("rst_inst_o", 32'(bus.inst_o), 32'h0);
    chk("rst_origaddr_o", 32'(bus.origaddr_o), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      set_in($urandom_range(0, 3) != 0, ADDR_W'($urandom), $urandom_range(0, 3) == 0,
             $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1, INST_W'($urandom),
             $urandom_range(0, 7) == 0);
      step();
    end
  endtask

  initial begin
    logic [INST_W-1:0] prog [4];
    prog[0] = 16'h1111; prog[1] = 16'h2222; prog[2] = 16'h3333; prog[3] = 16'h4444;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    #2;
    do_reset();

    // Load four words; requests in LOAD must be ignored.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, prog[i], 1'b0);
      step();
    end
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'hdead, 1'b1);
    step();

    set_in(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, '0, 1'b0); step();
    chk("fetch2_inst", 32'(bus.inst_o), 32'h3333);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, '0, 1'b0); step();
    end
    set_in(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, '0, 1'b0); step();
    set_in(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, '0, 1'b0); step();
    chk("flush_target_inst", 32'(bus.inst_o), 32'h4444);
    set_in(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0); step();
    set_in(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, '0, 1'b0); step();
    chk("wrap_inst", 32'(bus.inst_o), 32'h2222);
    set_in(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, '0, 1'b0); step();
    chk("flush_stall_v", 32'(bus.v_o), 32'h0);

    rand_cycles(300);

    // Reset mid-run, return to RUN on the kept program.
    do_reset();
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1); step();
    set_in(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, '0, 1'b0); step();
    chk("kept_inst", 32'(bus.inst_o), 32'h1111);

    // Partial reload; last word arrives with ld_done.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, INST_W'($urandom), i == 2);
      step();
    end
    rand_cycles(150);

    // Overfill: fifth word refused once the array is full.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, '0, 1'b0, 1'b0, 1'b1, INST_W'($urandom), 1'b0);
      step();
    end
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1); step();
    rand_cycles(150);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
